f_pc: RTL and testbench

Fetch-stage program counter of the five-stage pipelined CPU. Holds the F-stage PC register and selects the next PC from sequential increment, D-stage conditional branch (driven by the D-stage comparator's `branch` result), absolute jump, or register jump. Honours pipeline stalls and flags misaligned or out-of-range fetch addresses for the instruction memory interface.

---
 rtl/f_pc_pkg.sv | 18 +
 rtl/f_npc.sv | 43 ++++
 rtl/f_pc.sv | 62 ++++++
 tb/tb_f_pc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/f_pc_pkg.sv
// f_pc_pkg: shared definitions for the fetch stage.
// Holds the next-PC select codes driven by the D-stage controller and
// the default reset address of the program counter.
package f_pc_pkg;

  // Next-PC select codes; codes 4..7 are unused and fall back to sequential.
  typedef enum logic [2:0] {
    NPC_OP_SEQ    = 3'd0,
    NPC_OP_BRANCH = 3'd1,
    NPC_OP_JUMP   = 3'd2,
    NPC_OP_JR     = 3'd3
  } npc_op_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] IM_TOP_DEFAULT   = 32'h0000_6FFC;

endpackage

// File: rtl/f_npc.sv
// f_npc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_f    - current fetch address
//   pc_d    - PC of the instruction in D (source of branch/jump bases)
//   npcOp   - next-PC select code (see f_pc_pkg::npc_op_e)
//   branch  - D-stage compare result, 1 = taken
//   imm16   - branch offset in words
//   index26 - jump word index
//   rs_d    - forwarded register value for jr
//   npc     - selected next PC
module f_npc
  import f_pc_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [2:0]  npcOp,
  input  logic        branch,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_d,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] pc_d_plus4;
  logic [31:0] branch_off;

  // Branch and jump targets are formed relative to the delay-slot address,
  // which is pc_d + 4 (equal to pc_f whenever a transfer is evaluated).
  always_comb begin
    seq_pc     = pc_f + 32'd4;
    pc_d_plus4 = pc_d + 32'd4;
    branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    npc        = seq_pc;
    case (npcOp)
      NPC_OP_BRANCH: if (branch) npc = pc_d_plus4 + branch_off;
      NPC_OP_JUMP:   npc = {pc_d_plus4[31:28], index26, 2'b00};
      NPC_OP_JR:     npc = rs_d;
      default:       npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/f_pc.sv
// f_pc: fetch-stage program counter.
// Holds the F-stage PC, loads the next PC chosen by f_npc unless stalled,
// and flags illegal fetch addresses for the instruction memory.
// Ports:
//   clk        - rising-edge clock
//   reset_n    - synchronous active-low reset (wins over stall)
//   stall      - hold the PC this cycle
//   npcOp, branch, pc_d, imm16, index26, rs_d - D-stage next-PC inputs
//   pc_f       - current fetch address
//   pc_f_plus4 - pc_f + 4 for the F/D register
//   excAdEL    - fetch address misaligned or outside [IM_BASE, IM_TOP]
module f_pc
  import f_pc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter logic [31:0] IM_TOP   = IM_TOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [2:0]  npcOp,
  input  logic        branch,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_d,
  output logic [31:0] pc_f,
  output logic [31:0] pc_f_plus4,
  output logic        excAdEL
);

  logic [31:0] npc;

  f_npc u_npc (
    .pc_f    (pc_f),
    .pc_d    (pc_d),
    .npcOp   (npcOp),
    .branch  (branch),
    .imm16   (imm16),
    .index26 (index26),
    .rs_d    (rs_d),
    .npc     (npc)
  );

  // A stalled cycle drops the D-stage request entirely; the stalled
  // instruction re-presents it once the stall clears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_f <= PC_RESET;
    end else if (!stall) begin
      pc_f <= npc;
    end
  end

  // Wrapped or misaligned targets are loaded as-is and reported here.
  always_comb begin
    pc_f_plus4 = pc_f + 32'd4;
    excAdEL    = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_TOP);
  end

endmodule

// File: tb/tb_f_pc.sv
// tb_f_pc: self-checking bench for f_pc.
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the program counter kept in the bench.
module tb_f_pc;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam logic [31:0] TOP    = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  npcOp = 3'd0;
  logic        branch = 1'b0;
  logic [31:0] pc_d = 32'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] index26 = 26'd0;
  logic [31:0] rs_d = 32'd0;
  logic [31:0] pc_f;
  logic [31:0] pc_f_plus4;
  logic        excAdEL;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_pc = RST_PC;

  f_pc dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .npcOp      (npcOp),
    .branch     (branch),
    .pc_d       (pc_d),
    .imm16      (imm16),
    .index26    (index26),
    .rs_d       (rs_d),
    .pc_f       (pc_f),
    .pc_f_plus4 (pc_f_plus4),
    .excAdEL    (excAdEL)
  );

  always #5 clk = ~clk;

  // Reference next PC computed with plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur);
    logic [31:0] off;
    off = 32'($signed(imm16)) * 32'd4;
    case (npcOp)
      3'd1:    ref_next = branch ? pc_d + 32'd4 + off : cur + 32'd4;
      3'd2:    ref_next = ((pc_d + 32'd4) & 32'hF000_0000) | (32'(index26) * 32'd4);
      3'd3:    ref_next = rs_d;
      default: ref_next = cur + 32'd4;
    endcase
  endfunction

  function automatic logic ref_exc(input logic [31:0] a);
    ref_exc = ((a % 4) != 0) || (a < BASE) || (a > TOP);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".pc_f"}, pc_f, model_pc);
    checkOutput({tag, ".plus4"}, pc_f_plus4, model_pc + 32'd4);
    checkOutput({tag, ".exc"}, {31'd0, excAdEL}, {31'd0, ref_exc(model_pc)});
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample after.
  task automatic applyStimulus(input logic rn, input logic st, input logic [2:0] op,
                               input logic br, input logic [31:0] pd,
                               input logic [15:0] imm, input logic [25:0] idx,
                               input logic [31:0] rs);
    logic [31:0] nxt;
    reset_n = rn; stall = st; npcOp = op; branch = br;
    pc_d = pd; imm16 = imm; index26 = idx; rs_d = rs;
    if (!rn)      nxt = RST_PC;
    else if (st)  nxt = model_pc;
    else          nxt = ref_next(model_pc);
    @(posedge clk);
    model_pc = nxt;
    #1;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    applyStimulus(1'b1, 1'b0, 3'd3, 1'b0, 32'd0, 16'd0, 26'd0, tgt);
  endtask

  initial begin
    logic [31:0] rs_pick;
    logic [31:0] pd_pick;

    // Reset for two cycles then free run.
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    checkOutput("reset_pc", pc_f, 32'h3000);
    checkOutput("reset_plus4", pc_f_plus4, 32'h3004);
    checkOutput("reset_exc", {31'd0, excAdEL}, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    checkOutput("seq1", pc_f, 32'h3004);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    checkOutput("seq2", pc_f, 32'h3008);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    checkOutput("seq3", pc_f, 32'h300C);
    checkOutput("seq3_exc", {31'd0, excAdEL}, 32'd0);

    // Branch taken / not taken from pc_d = 3010 (pc_f = 3014).
    jr_to(32'h3014);
    applyStimulus(1'b1, 1'b0, 3'd1, 1'b1, 32'h3010, 16'hFFFC, 26'd0, 32'd0);
    checkOutput("br_taken", pc_f, 32'h3004);
    jr_to(32'h3014);
    applyStimulus(1'b1, 1'b0, 3'd1, 1'b0, 32'h3010, 16'hFFFC, 26'd0, 32'd0);
    checkOutput("br_not_taken", pc_f, 32'h3018);

    // Jump and register jumps.
    applyStimulus(1'b1, 1'b0, 3'd2, 1'b0, 32'h3020, 16'd0, 26'h0000C40, 32'd0);
    checkOutput("jump", pc_f, 32'h3100);
    jr_to(32'h3404);
    checkOutput("jr", pc_f, 32'h3404);
    jr_to(32'h3402);
    checkOutput("jr_mis", pc_f, 32'h3402);
    checkOutput("jr_mis_exc", {31'd0, excAdEL}, 32'd1);

    // Stall with a taken branch pending, then release.
    jr_to(32'h3014);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 32'h3010, 16'hFFFC, 26'd0, 32'd0);
      checkOutput("stall_hold", pc_f, 32'h3014);
    end
    applyStimulus(1'b1, 1'b0, 3'd1, 1'b1, 32'h3010, 16'hFFFC, 26'd0, 32'd0);
    checkOutput("stall_release", pc_f, 32'h3004);

    // Reset beats stall; release reset while still stalled.
    jr_to(32'h4000);
    applyStimulus(1'b0, 1'b1, 3'd3, 1'b0, 32'd0, 16'd0, 26'd0, 32'h5000);
    checkOutput("stall_reset", pc_f, 32'h3000);
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b0, 32'd0, 16'd0, 26'd0, 32'h5000);
    checkOutput("reset_mid_stall", pc_f, 32'h3000);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    checkOutput("resume", pc_f, 32'h3004);

    // Address range edges.
    jr_to(32'h6FFC);
    checkOutput("top_exc", {31'd0, excAdEL}, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    checkOutput("over_pc", pc_f, 32'h7000);
    checkOutput("over_exc", {31'd0, excAdEL}, 32'd1);
    jr_to(32'h2FFC);
    checkOutput("under_exc", {31'd0, excAdEL}, 32'd1);
    jr_to(32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0);
    checkOutput("wrap_pc", pc_f, 32'h0);
    checkOutput("wrap_exc", {31'd0, excAdEL}, 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       rs_pick = $urandom;
        1:       rs_pick = BASE - 32'($urandom_range(0, 8));
        2:       rs_pick = TOP + 32'($urandom_range(0, 8));
        default: rs_pick = BASE + (32'($urandom_range(0, 32'h3FFF)) & 32'hFFFF_FFFC)
                           + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      endcase
      pd_pick = ($urandom_range(0, 3) == 0) ? $urandom : model_pc - 32'd4;
      applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    pd_pick, 16'($urandom), 26'($urandom), rs_pick);
      checkModel("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
